// File: rtl/ps_lane_if.sv
// Lane-side signal bundle for ps_lane: striped byte input, serial output and status.
// The master modport belongs to the striping stage; the slave modport belongs to ps_lane.
interface ps_lane_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       byte_req;
    logic       active;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  byte_req,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output byte_req,
        output active
    );
endinterface

// File: rtl/ps_lane.sv
// Per-lane parallel-to-serial converter: sends SYNC_COUNT COM bytes after reset, then lane bytes.
// Define PS_LANE_LSB_FIRST_EN to serialise each byte LSB first (default is MSB first).
module ps_lane #(
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    ps_lane_if.slave   lane
);

    typedef enum logic [0:0] {
        StSync,
        StActive
    } state_e;

    state_e     state_q;
    logic [3:0] sync_cnt_q;
    logic       active_q;

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       load;
    logic [7:0] next_byte;
    logic [7:0] load_byte;

    assign load = (cnt_q == 3'd7);

    always_comb begin
        cnt_d     = cnt_q + 3'd1;
        next_byte = IDLE_CHAR;
        if (state_q == StActive && lane.valid_in) begin
            next_byte = lane.data_in;
        end
`ifdef PS_LANE_LSB_FIRST_EN
        load_byte = '0;
        for (int i = 0; i < 8; i++) begin
            load_byte[i] = next_byte[7-i];
        end
`else
        load_byte = next_byte;
`endif
        shreg_d = load ? load_byte : {shreg_q[6:0], 1'b0};
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q   <= 3'd0;
            shreg_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // The edge that loads the last training COM is also the edge that enters StActive.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= StSync;
            sync_cnt_q <= 4'd0;
            active_q   <= 1'b0;
        end else if (load) begin
            case (state_q)
                StSync: begin
                    sync_cnt_q <= sync_cnt_q + 4'd1;
                    if (sync_cnt_q == 4'(SYNC_COUNT - 1)) begin
                        state_q  <= StActive;
                        active_q <= 1'b1;
                    end
                end
                StActive: begin
                    state_q  <= StActive;
                    active_q <= 1'b1;
                end
                default: begin
                    state_q  <= StSync;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign lane.data_out = shreg_q[7];
    assign lane.byte_req = load;
    assign lane.active   = active_q;

endmodule

// File: tb/tb_ps_lane.sv
// Self-checking bench for ps_lane: edge-count reference model plus directed literal checks.
module tb_ps_lane;

    localparam logic [7:0]  IDLE = 8'hBC;
    localparam int unsigned SYNC = 4;
`ifdef PS_LANE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    // Expected bytes as they arrive on the wire, first bit in the MSB position.
    localparam logic [7:0] COM_S = LSB ? 8'h3D : 8'hBC;
    localparam logic [7:0] P55_S = LSB ? 8'hAA : 8'h55;

    logic clk_8f = 1'b0;
    logic reset_L;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    always #5 clk_8f = ~clk_8f;

    ps_lane_if lane_if ();

    ps_lane #(
        .IDLE_CHAR  (IDLE),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .lane    (lane_if)
    );

    // Model: n = rising edges since reset release; byte k is loaded at edge 8k.
    int unsigned n;
    logic [7:0]  cur_byte;
    int unsigned k;

    always @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            n        <= 0;
            cur_byte <= 8'h00;
        end else begin
            n <= n + 1;
            if ((n + 1) % 8 == 0) begin
                k = (n + 1) / 8;
                if (k <= SYNC || !lane_if.valid_in) cur_byte <= IDLE;
                else                                cur_byte <= lane_if.data_in;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_8f) begin
        if (cmp_en) begin
            int  idx;
            logic e_dout;
            idx    = int'(n % 8);
            e_dout = LSB ? cur_byte[idx] : cur_byte[7-idx];
            chk("data_out", {7'd0, lane_if.data_out}, {7'd0, e_dout});
            chk("byte_req", {7'd0, lane_if.byte_req}, {7'd0, (n % 8 == 7)});
            chk("active",   {7'd0, lane_if.active},   {7'd0, (n >= 8 * SYNC)});
        end
    end

    task automatic wait_load();
        int g = 0;
        while (!(n % 8 == 0 && n >= 8) && g < 40) begin
            @(negedge clk_8f);
            g++;
        end
        if (g >= 40) begin
            tests++;
            fails++;
            $display("FAIL wait_load: got timeout, expected load edge");
        end
    endtask

    // Starts on the negedge of a cnt=0 cycle; ends on the negedge of the next cnt=0 cycle.
    task automatic get_byte(output logic [7:0] b);
        b = 8'h00;
        repeat (8) begin
            b = {b[6:0], lane_if.data_out};
            @(negedge clk_8f);
        end
    endtask

    task automatic release_reset();
        repeat (5) @(negedge clk_8f);
        #2 reset_L = 1'b1;
        @(negedge clk_8f);
    endtask

    initial begin
        logic [7:0] b;
        int         g;
        reset_L          = 1'b1;
        lane_if.valid_in = 1'b1;
        lane_if.data_in  = 8'h55;
        #1 reset_L = 1'b0;
        #1 cmp_en  = 1'b1;
        chk("rst_dout",   {7'd0, lane_if.data_out}, 8'd0);
        chk("rst_req",    {7'd0, lane_if.byte_req}, 8'd0);
        chk("rst_active", {7'd0, lane_if.active},   8'd0);
        release_reset();

        for (int i = 0; i < 4; i++) begin
            wait_load();
            chk("train_active", {7'd0, lane_if.active}, {7'd0, (i == 3)});
            get_byte(b);
            chk("train_com", b, COM_S);
        end
        chk("active_after_train", {7'd0, lane_if.active}, 8'd1);

        lane_if.data_in = 8'hA5;
        get_byte(b);
        chk("first_data_55", b, P55_S);
        lane_if.data_in = 8'hFF;
        get_byte(b);
        chk("data_a5", b, 8'hA5);
        lane_if.data_in = 8'h00;
        get_byte(b);
        chk("data_ff", b, 8'hFF);
        lane_if.valid_in = 1'b0;
        get_byte(b);
        chk("data_00", b, 8'h00);
        lane_if.valid_in = 1'b1;
        lane_if.data_in  = 8'hFF;
        get_byte(b);
        chk("idle_fill", b, COM_S);

        // Drop reset in the middle of an all-ones byte.
        g = 0;
        while (!(n % 8 == 3 && n > 88) && g < 40) begin
            @(negedge clk_8f);
            g++;
        end
        if (g >= 40) begin
            tests++;
            fails++;
            $display("FAIL mid_wait: got timeout, expected cnt=3");
        end
        chk("pre_rst_dout", {7'd0, lane_if.data_out}, 8'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("async_dout",   {7'd0, lane_if.data_out}, 8'd0);
        chk("async_req",    {7'd0, lane_if.byte_req}, 8'd0);
        chk("async_active", {7'd0, lane_if.active},   8'd0);
        lane_if.data_in = 8'h55;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            wait_load();
            get_byte(b);
            chk("retrain_com", b, COM_S);
        end
        get_byte(b);
        chk("retrain_data", b, P55_S);

        repeat (700) begin
            @(negedge clk_8f);
            lane_if.valid_in = 1'($urandom_range(0, 1));
            lane_if.data_in  = 8'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                #2 reset_L = 1'b0;
                repeat (2) @(negedge clk_8f);
                #2 reset_L = 1'b1;
            end
        end

        @(negedge clk_8f);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
